// File: rtl/spsram_arb_pkg.sv
// Shared constants and types for the single-port parameter-RAM arbiter.
package spsram_arb_pkg;

    // Geometry of the attached spsram512x32.
    localparam int SPSRAM_AW = 9;
    localparam int SPSRAM_DW = 32;

    // Read latency of the synthesized XPM and of the behavioural model.
    localparam int SPSRAM_RD_LAT_SYN = 2;
    localparam int SPSRAM_RD_LAT_SIM = 1;

    // Tag id is sized for the largest supported requester count (8).
    localparam int MAX_REQ  = 8;
    localparam int REQ_ID_W = $clog2(MAX_REQ);

    // One in-flight read: valid flag plus the requester it belongs to.
    typedef struct packed {
        logic                vld;
        logic [REQ_ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/spsram_arb_rr_pick.sv
// Combinational round-robin picker: grants the first set request found
// searching upward from ptr+1 (modulo N). Stateless, reusable.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int c;

    // Rotating priority search; the first hit sets any and blocks later hits.
    // NOTE: every output gets a default before the loop so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                gnt[c] = 1'b1;
                idx    = IW'(c);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spsram_arb.sv
// Round-robin arbiter sharing one single-port RAM among N_REQ requesters.
// One access per cycle; reads are tracked by a latency-matched tag pipeline
// and their data is steered back to the issuing requester.
module spsram_arb
    import spsram_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int AW     = SPSRAM_AW,
    parameter int DW     = SPSRAM_DW,
    parameter int RD_LAT = SPSRAM_RD_LAT_SYN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ-1:0][AW-1:0]  req_addr,
    input  logic [N_REQ-1:0][DW-1:0]  req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DW-1:0]             rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_din,
    input  logic [DW-1:0]             mem_dout
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic             gnt_any;
    rd_tag_t          tag_q [RD_LAT];

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // The grant is the handshake: valid is already folded into the pick.
    assign req_ready = gnt;

    // Drive the granted request straight onto the RAM port; idle drives zeros.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (gnt_any) begin
            mem_en   = 1'b1;
            mem_we   = req_we[gnt_idx];
            mem_addr = req_addr[gnt_idx];
            mem_din  = req_wdata[gnt_idx];
        end
    end

    // Remember the last accepted requester; reset makes requester 0 win first.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(N_REQ - 1);
        end else if (gnt_any) begin
            ptr <= gnt_idx;
        end
    end

    // Tag pipeline matched to RAM latency; shifts every cycle, no backpressure.
    // NOTE: the tags are reset (a stale vld would fire a bogus response), while
    // the RAM array and its data pipeline need no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].vld <= gnt_any & ~mem_we;
            tag_q[0].id  <= REQ_ID_W'(gnt_idx);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Decode the last stage into a one-hot strobe back to the issuer.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].id == REQ_ID_W'(i));
        end
    end

    // Read data is shared and ungated; only rsp_valid qualifies it.
    assign rsp_rdata = mem_dout;

endmodule

// File: tb/tb_spsram_arb.sv
// Scoreboard bench for spsram_arb: one instance at RD_LAT=2 and one at
// RD_LAT=1, each with an inline behavioural RAM of matching latency.
module tb_spsram_arb;
    import spsram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = SPSRAM_AW;
    localparam int DW = SPSRAM_DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 (RD_LAT=2) signals.
    logic [N-1:0]         valid0, we0, ready0, rspv0;
    logic [N-1:0][AW-1:0] addr0;
    logic [N-1:0][DW-1:0] wdata0;
    logic [DW-1:0]        rdata0, mdin0, mdout0;
    logic                 en0, mwe0;
    logic [AW-1:0]        maddr0;

    // Instance 1 (RD_LAT=1) signals.
    logic [N-1:0]         valid1, we1, ready1, rspv1;
    logic [N-1:0][AW-1:0] addr1;
    logic [N-1:0][DW-1:0] wdata1;
    logic [DW-1:0]        rdata1, mdin1, mdout1;
    logic                 en1, mwe1;
    logic [AW-1:0]        maddr1;

    spsram_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(SPSRAM_RD_LAT_SYN)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid0), .req_ready(ready0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wdata0),
        .rsp_valid(rspv0), .rsp_rdata(rdata0),
        .mem_en(en0), .mem_we(mwe0), .mem_addr(maddr0),
        .mem_din(mdin0), .mem_dout(mdout0)
    );

    spsram_arb #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(SPSRAM_RD_LAT_SIM)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid1), .req_ready(ready1), .req_we(we1),
        .req_addr(addr1), .req_wdata(wdata1),
        .rsp_valid(rspv1), .rsp_rdata(rdata1),
        .mem_en(en1), .mem_we(mwe1), .mem_addr(maddr1),
        .mem_din(mdin1), .mem_dout(mdout1)
    );

    // Behavioural write-first RAMs; contents are preloaded while reset is low.
    logic [DW-1:0] ram0 [512];
    logic [DW-1:0] rp0 [2];
    logic [DW-1:0] ram1 [512];
    logic [DW-1:0] rp1;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ram0[i] <= 32'hA0A0_0000 | i;
            ram0[9'h010] <= 32'h1111_1111;
        end else if (en0) begin
            if (mwe0) begin
                ram0[maddr0] <= mdin0;
                rp0[0]       <= mdin0;
            end else begin
                rp0[0] <= ram0[maddr0];
            end
        end
        rp0[1] <= rp0[0];
    end
    assign mdout0 = rp0[1];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) ram1[i] <= 32'hA0A0_0000 | i;
        end else if (en1) begin
            if (mwe1) begin
                ram1[maddr1] <= mdin1;
                rp1          <= mdin1;
            end else begin
                rp1 <= ram1[maddr1];
            end
        end
    end
    assign mdout1 = rp1;

    // Scoreboard.
    typedef struct {
        logic [N-1:0]  vld;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance 0: any strobe must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0 && q0[0].due < cyc) begin
            e = q0.pop_front();
            check("rsp0_missing", 64'(e.due), 64'(cyc));
        end
        if (rspv0 !== '0) begin
            if (q0.size() == 0) begin
                check("rsp0_unexpected", 64'(rspv0), 64'(0));
            end else begin
                e = q0.pop_front();
                check("rsp0_valid", 64'(rspv0), 64'(e.vld));
                check("rsp0_data", 64'(rdata0), 64'(e.data));
                check("rsp0_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() != 0 && q1[0].due < cyc) begin
            e = q1.pop_front();
            check("rsp1_missing", 64'(e.due), 64'(cyc));
        end
        if (rspv1 !== '0) begin
            if (q1.size() == 0) begin
                check("rsp1_unexpected", 64'(rspv1), 64'(0));
            end else begin
                e = q1.pop_front();
                check("rsp1_valid", 64'(rspv1), 64'(e.vld));
                check("rsp1_data", 64'(rdata1), 64'(e.data));
                check("rsp1_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic set0(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid0[i] = 1'b1; we0[i] = we; addr0[i] = a; wdata0[i] = d;
    endtask

    task automatic clr0();
        valid0 = '0; we0 = '0; addr0 = '0; wdata0 = '0;
    endtask

    task automatic set1(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid1[i] = 1'b1; we1[i] = we; addr1[i] = a; wdata1[i] = d;
    endtask

    task automatic clr1();
        valid1 = '0; we1 = '0; addr1 = '0; wdata1 = '0;
    endtask

    // One cycle on instance 0: check grant and RAM drive, queue expected read.
    task automatic cycle0(input logic [N-1:0] exp_rdy, input logic [DW-1:0] exp_data);
        int g;
        g = 0;
        @(negedge clk);
        check("ready0", 64'(ready0), 64'(exp_rdy));
        check("mem_en0", 64'(en0), 64'(|exp_rdy));
        if (exp_rdy != '0) begin
            for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
            check("mem_we0", 64'(mwe0), 64'(we0[g]));
            check("mem_addr0", 64'(maddr0), 64'(addr0[g]));
            if (we0[g]) check("mem_din0", 64'(mdin0), 64'(wdata0[g]));
            else q0.push_back('{exp_rdy, exp_data, cyc + 2});
        end
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance 1 (single-cycle RAM).
    task automatic cycle1(input logic [N-1:0] exp_rdy, input logic [DW-1:0] exp_data);
        int g;
        g = 0;
        @(negedge clk);
        check("ready1", 64'(ready1), 64'(exp_rdy));
        check("mem_en1", 64'(en1), 64'(|exp_rdy));
        if (exp_rdy != '0) begin
            for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
            check("mem_addr1", 64'(maddr1), 64'(addr1[g]));
            if (!we1[g]) q1.push_back('{exp_rdy, exp_data, cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr0();
        clr1();
        repeat (3) @(posedge clk);
        #1;

        // Reset: everything quiet.
        check("rst_ready0", 64'(ready0), 64'(0));
        check("rst_rspv0", 64'(rspv0), 64'(0));
        check("rst_en0", 64'(en0), 64'(0));
        check("rst_we0", 64'(mwe0), 64'(0));
        check("rst_addr0", 64'(maddr0), 64'(0));
        check("rst_din0", 64'(mdin0), 64'(0));
        check("rst_ready1", 64'(ready1), 64'(0));
        check("rst_rspv1", 64'(rspv1), 64'(0));

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First grant goes to 0, then 3.
        set0(0, 1'b0, 9'h000, '0);
        set0(3, 1'b0, 9'h003, '0);
        cycle0(4'b0001, 32'hA0A0_0000);
        cycle0(4'b1000, 32'hA0A0_0003);

        // Write then read at the top address.
        clr0();
        set0(1, 1'b1, 9'h1FF, 32'hDEAD_BEEF);
        cycle0(4'b0010, '0);
        clr0();
        set0(2, 1'b0, 9'h1FF, '0);
        cycle0(4'b0100, 32'hDEAD_BEEF);

        // Full contention, ptr=2 so the rotation starts at 3.
        clr0();
        for (int i = 0; i < N; i++) set0(i, 1'b0, AW'(i), '0);
        for (int k = 0; k < 8; k++) begin
            cycle0(4'(1 << ((3 + k) % 4)), 32'hA0A0_0000 | ((3 + k) % 4));
        end

        // Read before write returns old data; the later read sees new data.
        clr0();
        set0(0, 1'b0, 9'h010, '0);
        cycle0(4'b0001, 32'h1111_1111);
        clr0();
        set0(1, 1'b1, 9'h010, 32'h2222_2222);
        cycle0(4'b0010, '0);
        clr0();
        set0(2, 1'b0, 9'h010, '0);
        repeat (3) cycle0(4'b0100, 32'h2222_2222);
        clr0();
        repeat (3) cycle0(4'b0000, '0);

        // Reset with two reads in flight.
        set0(0, 1'b0, 9'h000, '0);
        set0(1, 1'b0, 9'h001, '0);
        cycle0(4'b0001, 32'hA0A0_0000);
        cycle0(4'b0010, 32'hA0A0_0001);
        check("rsp_before_reset", 64'(rspv0), 64'(4'b0001));
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("rsp_on_reset", 64'(rspv0), 64'(0));
        clr0();
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) cycle0(4'b0000, '0);
        for (int i = 0; i < N; i++) set0(i, 1'b0, AW'(i), '0);
        cycle0(4'b0001, 32'hA0A0_0000);
        clr0();
        repeat (3) cycle0(4'b0000, '0);

        // RD_LAT=1: lone requester back-to-back, then two alternating.
        for (int k = 0; k < 4; k++) begin
            clr1();
            set1(0, 1'b0, AW'(k), '0);
            cycle1(4'b0001, 32'hA0A0_0000 | k);
        end
        clr1();
        set1(0, 1'b0, 9'h002, '0);
        set1(1, 1'b0, 9'h003, '0);
        cycle1(4'b0010, 32'hA0A0_0003);
        cycle1(4'b0001, 32'hA0A0_0002);
        cycle1(4'b0010, 32'hA0A0_0003);
        cycle1(4'b0001, 32'hA0A0_0002);
        clr1();
        set1(2, 1'b1, 9'h005, 32'hCAFE_F00D);
        cycle1(4'b0100, '0);
        clr1();
        set1(3, 1'b0, 9'h005, '0);
        cycle1(4'b1000, 32'hCAFE_F00D);
        clr1();
        repeat (3) cycle1(4'b0000, '0);

        check("q0_drained", 64'(q0.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
